mul_seq: RTL and testbench

- Sequential radix-2 shift-add multiplier for the RV64M multiply group: MUL, MULH, MULHSU, MULHU, MULW.
- Performs the inverse operation of the EXU's iterative divider and uses the same request/complete handshake, so the EXU stall logic treats both units identically.
- Sits in the EXU beside the divider; the result goes to the writeback mux.

---
 rtl/mul_seq_pkg.sv | 10 +
 rtl/mul_abs_neg.sv | 10 +
 rtl/mul_seq.sv | 98 +++++++++
 tb/tb_mul_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared widths, signedness encodings, FSM states and iteration counts
package mul_seq_pkg;
   localparam int XLEN = 64;
   localparam logic [1:0] MUL_UU = 2'b00;
   localparam logic [1:0] MUL_SS = 2'b11;
   localparam logic [1:0] MUL_SU = 2'b10;
   localparam logic [6:0] CNT_D = 7'd64;
   localparam logic [6:0] CNT_W = 7'd32;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mul_abs_neg.sv
// mul_abs_neg: conditional two's-complement negate of a W-bit value
module mul_abs_neg #(
   parameter int W = 64
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);
   assign o_val = i_neg ? ~i_val + W'(1) : i_val;
endmodule

// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW
// MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int XLEN = mul_seq_pkg::XLEN
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            mul,
   input  logic            w,
   input  logic [1:0]      mul_signed,
   input  logic            high,
   input  logic [XLEN-1:0] multiplicand,
   input  logic [XLEN-1:0] multiplier,
   output logic [XLEN-1:0] result,
   output logic            complete
);
   state_t              r_state, w_state_n;
   logic [6:0]          r_count;
   logic [XLEN-1:0]     r_mcand, r_mplier, r_result;
   logic [2*XLEN-1:0]   r_acc, w_acc_step, w_acc_n, w_prod;
   logic                r_neg, r_w, r_high, r_complete;
   logic                w_a_sgn, w_b_sgn, w_last;
   logic [XLEN-1:0]     w_a_abs, w_b_abs, w_res;
   logic [XLEN:0]       w_sum;

   // 32-bit ops are unsigned in the low half, so sign handling is suppressed for w
   assign w_a_sgn = mul_signed[1] & multiplicand[XLEN-1] & ~w;
   assign w_b_sgn = (mul_signed == MUL_SS) & multiplier[XLEN-1] & ~w;

   mul_abs_neg #(.W(XLEN)) u_abs_a (.i_neg(w_a_sgn), .i_val(multiplicand), .o_val(w_a_abs));
   mul_abs_neg #(.W(XLEN)) u_abs_b (.i_neg(w_b_sgn), .i_val(multiplier), .o_val(w_b_abs));

   assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_step = {w_sum, r_acc[XLEN-1:1]};

`ifdef MUL_EARLY_EXIT_EN
   logic w_early;
   assign w_early = (r_mplier == '0);
   assign w_acc_n = w_early ? r_acc >> r_count : w_acc_step;
   assign w_last  = w_early | (r_count == 7'd1);
`else
   assign w_acc_n = w_acc_step;
   assign w_last  = (r_count == 7'd1);
`endif

   mul_abs_neg #(.W(2*XLEN)) u_fix (.i_neg(r_neg), .i_val(w_acc_n), .o_val(w_prod));

   // after 32 iterations the 64-bit w product sits in acc[95:32]
   assign w_res = r_w    ? {{32{w_prod[63]}}, w_prod[63:32]} :
                  r_high ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

   always_comb begin
      w_state_n = IDLE;
      case (r_state)
         IDLE:    w_state_n = mul ? BUSY : IDLE;
         BUSY:    w_state_n = !mul ? IDLE : w_last ? DONE : BUSY;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_neg      <= 1'b0;
         r_w        <= 1'b0;
         r_high     <= 1'b0;
         r_result   <= '0;
         r_complete <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_complete <= (r_state == BUSY) & mul & w_last;
         if (r_state == IDLE && mul) begin
            r_mcand  <= w ? {32'b0, multiplicand[31:0]} : w_a_abs;
            r_mplier <= w ? {32'b0, multiplier[31:0]} : w_b_abs;
            r_acc    <= '0;
            r_neg    <= w_a_sgn ^ w_b_sgn;
            r_w      <= w;
            r_high   <= high;
            r_count  <= w ? CNT_W : CNT_D;
         end
         if (r_state == BUSY) begin
            r_acc    <= w_acc_n;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 7'd1;
            if (mul && w_last) r_result <= w_res;
         end
      end
   end

   assign result   = r_result;
   assign complete = r_complete;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors plus a cycle-level arithmetic reference model for mul_seq
module tb_mul_seq;
   logic        clock = 1'b0;
   logic        reset, mul, w, high;
   logic [1:0]  mul_signed;
   logic [63:0] multiplicand, multiplier, result;
   logic        complete;
   int          checks = 0, errors = 0;
   logic        en = 1'b0;

   int          m_st = 0, m_left = 0;
   logic        m_cmp = 1'b0, m_w = 1'b0, m_h = 1'b0;
   logic [1:0]  m_sg = 2'b00;
   logic [63:0] m_a = '0, m_b = '0, m_res = '0;

   mul_seq dut (
      .clock(clock), .reset(reset), .mul(mul), .w(w), .mul_signed(mul_signed), .high(high),
      .multiplicand(multiplicand), .multiplier(multiplier), .result(result), .complete(complete)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic ww, input logic hh, input logic [1:0] sg,
                                           input logic [63:0] a, input logic [63:0] b);
      logic signed [129:0] pa, pb, pr;
      logic [63:0] p32;
      if (ww) begin
         p32 = {32'b0, a[31:0]} * {32'b0, b[31:0]};
         return {{32{p32[31]}}, p32[31:0]};
      end
      pa = sg[1] ? {{66{a[63]}}, a} : {66'b0, a};
      pb = (sg == 2'b11) ? {{66{b[63]}}, b} : {66'b0, b};
      pr = pa * pb;
      return hh ? pr[127:64] : pr[63:0];
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_st = 0; m_cmp = 1'b0; m_res = '0;
      end else begin
         m_cmp = 1'b0;
         if (m_st == 0) begin
            if (mul) begin
               m_st = 1; m_left = w ? 32 : 64;
               m_w = w; m_h = high; m_sg = mul_signed; m_a = multiplicand; m_b = multiplier;
            end
         end else if (m_st == 1) begin
            if (!mul) m_st = 0;
            else begin
               m_left--;
               if (m_left == 0) begin
                  m_st = 2; m_cmp = 1'b1; m_res = ref_mul(m_w, m_h, m_sg, m_a, m_b);
               end
            end
         end else m_st = 0;
      end
   end

   always @(negedge clock) begin
      if (en) begin
         chk("model_complete", {63'b0, complete}, {63'b0, m_cmp});
         chk("model_result", result, m_res);
      end
   end

   task automatic run_op(input string name, input logic ww, input logic [1:0] sg, input logic hh,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_cyc);
      int cyc = 0;
      logic got = 1'b0;
      @(posedge clock); #1;
      mul = 1'b1; w = ww; mul_signed = sg; high = hh; multiplicand = a; multiplier = b;
      while (cyc < 200 && !got) begin
         @(negedge clock);
         if (complete) got = 1'b1;
         else begin
            cyc++;
            if (cyc == 3) begin
               w = ~ww; mul_signed = ~sg; high = ~hh; multiplicand = $urandom; multiplier = $urandom;
            end
         end
      end
      chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
      chk({name, "_result"}, result, exp);
      @(posedge clock); #1;
      mul = 1'b0;
   endtask

   initial begin
      int seen;
      reset = 1'b1; mul = 1'b0; w = 1'b0; high = 1'b0; mul_signed = 2'b00;
      multiplicand = '0; multiplier = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0; en = 1'b1;
      @(negedge clock);
      chk("reset_result", result, 64'h0);
      chk("reset_complete", {63'b0, complete}, 64'h0);

      run_op("mul_3x5",   1'b0, 2'b00, 1'b0, 64'd3, 64'd5, 64'h000000000000000F, 65);
      run_op("mulh_neg",  1'b0, 2'b11, 1'b1, 64'h8000000000000000, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
      run_op("mul_negl",  1'b0, 2'b11, 1'b0, 64'h8000000000000000, 64'd2, 64'h0, 65);
      run_op("mulhu_max", 1'b0, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 65);
      run_op("mulhsu",    1'b0, 2'b10, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
      run_op("reserved01",1'b0, 2'b01, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'h0000000000000001, 65);
      run_op("mul_neg15", 1'b0, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFD, 64'd5, 64'hFFFFFFFFFFFFFFF1, 65);
      run_op("mulw_ovf",  1'b1, 2'b00, 1'b0, 64'h000000007FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 33);
      run_op("mulw_hi",   1'b1, 2'b11, 1'b1, 64'hDEAD000000000003, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, 33);
      run_op("mul_zero",  1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 64'h0, 65);

      @(posedge clock); #1;
      mul = 1'b1; w = 1'b0; mul_signed = 2'b00; high = 1'b0; multiplicand = 64'd9; multiplier = 64'd9;
      repeat (10) @(posedge clock);
      #1 mul = 1'b0;
      seen = 0;
      repeat (80) begin
         @(negedge clock);
         if (complete) seen++;
      end
      chk("abort_no_complete", 64'(seen), 64'd0);
      chk("abort_result_kept", result, 64'h0);

      run_op("mul_7x6", 1'b0, 2'b00, 1'b0, 64'd7, 64'd6, 64'd42, 65);

      @(posedge clock); #1;
      mul = 1'b1; multiplicand = 64'd11; multiplier = 64'd13;
      repeat (20) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; mul = 1'b0;
      @(negedge clock);
      chk("reset_mid_complete", {63'b0, complete}, 64'h0);
      chk("reset_mid_result", result, 64'h0);
      seen = 0;
      repeat (70) begin
         @(negedge clock);
         if (complete) seen++;
      end
      chk("reset_no_late_complete", 64'(seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
